// File: rtl/fp16_mul_seq.sv
// fp16_mul_seq: multi-cycle IEEE-754 binary16 multiplier sequencer.
// One operand pair is accepted per operation. The 11x11 mantissa product is
// built over 11 shift-add cycles, then normalized (truncating) and packed.
// The result and flags are held until the consumer accepts them.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   opA_i/opB_i  operands {sign, exp[4:0], frac[9:0]}
//   req_valid_i  operand pair valid;  req_ready_o  block idle and can accept
//   res_o        packed product;      flags_o {invalid, overflow, underflow}
//   res_valid_o  result valid;        res_ready_i consumer accepts result
//   busy_o       high in any state other than IDLE
module fp16_mul_seq #(
    parameter bit OVF_SAT = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] opA_i,
    input  logic [15:0] opB_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    output logic [15:0] res_o,
    output logic [2:0]  flags_o,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_NORM, S_DONE} state_t;

    state_t             state;
    logic               sign;
    logic [10:0]        ma;
    logic [10:0]        mb;
    logic signed [6:0]  esum;
    logic               cls_invalid;
    logic               cls_inf;
    logic               cls_zero;
    logic [21:0]        acc;
    logic [3:0]         cnt;

    // Operand classification on the raw inputs; latched on the accept edge.
    logic [4:0] a_exp, b_exp;
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    always_comb begin
        a_exp  = opA_i[14:10];
        b_exp  = opB_i[14:10];
        a_zero = (a_exp == '0);
        b_zero = (b_exp == '0);
        a_inf  = (a_exp == '1) && (opA_i[9:0] == '0);
        b_inf  = (b_exp == '1) && (opB_i[9:0] == '0);
        a_nan  = (a_exp == '1) && (opA_i[9:0] != '0);
        b_nan  = (b_exp == '1) && (opB_i[9:0] != '0);
    end

    // Normalization and result packing from the finished accumulator.
    logic signed [6:0] e_norm;
    logic [9:0]        frac_norm;
    logic [15:0]       res_next;
    logic [2:0]        flags_next;

    always_comb begin
        if (acc[21]) begin
            frac_norm = acc[20:11];
            e_norm    = esum + 7'sd1;
        end else begin
            frac_norm = acc[19:10];
            e_norm    = esum;
        end
        flags_next = '0;
        if (cls_invalid) begin
            res_next      = 16'h7E00;
            flags_next[2] = 1'b1;
        end else if (cls_inf) begin
            res_next = {sign, 5'h1F, 10'h000};
        end else if (cls_zero) begin
            res_next = {sign, 15'h0000};
        end else if (e_norm >= 7'sd31) begin
            res_next      = OVF_SAT ? {sign, 5'h1E, 10'h3FF} : {sign, 5'h1F, 10'h000};
            flags_next[1] = 1'b1;
        end else if (e_norm <= 7'sd0) begin
            res_next      = {sign, 15'h0000};
            flags_next[0] = 1'b1;
        end else begin
            res_next = {sign, e_norm[4:0], frac_norm};
        end
    end

    assign req_ready_o = (state == S_IDLE);
    assign busy_o      = (state != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            sign        <= 1'b0;
            ma          <= '0;
            mb          <= '0;
            esum        <= '0;
            cls_invalid <= 1'b0;
            cls_inf     <= 1'b0;
            cls_zero    <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            res_o       <= '0;
            flags_o     <= '0;
            res_valid_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        sign        <= opA_i[15] ^ opB_i[15];
                        ma          <= {1'b1, opA_i[9:0]};
                        mb          <= {1'b1, opB_i[9:0]};
                        esum        <= $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - 7'sd15;
                        cls_invalid <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
                        cls_inf     <= a_inf | b_inf;
                        cls_zero    <= a_zero | b_zero;
                        acc         <= '0;
                        cnt         <= '0;
                        state       <= S_MULT;
                    end
                end
                S_MULT: begin
                    if (mb[cnt]) begin
                        acc <= acc + ({11'd0, ma} << cnt);
                    end
                    if (cnt == 4'd10) begin
                        state <= S_NORM;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_NORM: begin
                    res_o       <= res_next;
                    flags_o     <= flags_next;
                    res_valid_o <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_mul_seq.sv
// Directed testbench for fp16_mul_seq. Two instances share all inputs: one
// with infinity on overflow, one saturating to max finite.
module tb_fp16_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] opA, opB;
    logic        req_valid, res_ready;

    logic        req_ready, res_valid, busy;
    logic [15:0] res;
    logic [2:0]  flags;
    logic        req_ready_s, res_valid_s, busy_s;
    logic [15:0] res_s;
    logic [2:0]  flags_s;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fp16_mul_seq #(.OVF_SAT(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .opA_i(opA), .opB_i(opB),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .res_o(res), .flags_o(flags), .res_valid_o(res_valid),
        .res_ready_i(res_ready), .busy_o(busy)
    );

    fp16_mul_seq #(.OVF_SAT(1'b1)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .opA_i(opA), .opB_i(opB),
        .req_valid_i(req_valid), .req_ready_o(req_ready_s),
        .res_o(res_s), .flags_o(flags_s), .res_valid_o(res_valid_s),
        .res_ready_i(res_ready), .busy_o(busy_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one pair and wait (bounded) for the result; returns the latency
    // in cycles after the accept edge, or 99 if it never appeared.
    task automatic issue_and_wait(input string tag, input logic [15:0] a,
                                  input logic [15:0] b, output int lat);
        check({tag, "_ready_pre"}, req_ready, 1);
        opA = a; opB = b; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        opA = 16'h7E55; opB = 16'h1234;
        check({tag, "_ready_low"}, req_ready, 0);
        check({tag, "_busy"}, busy, 1);
        lat = 99;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (res_valid) begin
                lat = n;
                break;
            end
            if (req_ready) begin
                check({tag, "_ready_while_busy"}, req_ready, 0);
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic [2:0] ef, input logic [15:0] er_sat);
        int lat;
        res_ready = 1'b1;
        issue_and_wait(tag, a, b, lat);
        check({tag, "_latency"}, lat, 12);
        check({tag, "_res"}, res, er);
        check({tag, "_flags"}, flags, ef);
        check({tag, "_res_sat"}, res_s, er_sat);
        check({tag, "_valid_sat"}, res_valid_s, 1);
        tick();
        check({tag, "_valid_1cyc"}, res_valid, 0);
        check({tag, "_ready_after"}, req_ready, 1);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; opA = '0; opB = '0; req_valid = 1'b0; res_ready = 1'b0;
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_valid", res_valid, 0);
        check("rst_res", res, 0);
        check("rst_flags", flags, 0);
        check("rst_busy", busy, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // basic, sign, truncation
        run_op("mul_1p5x2",   16'h3E00, 16'h4000, 16'h4200, 3'b000, 16'h4200);
        run_op("neg_exact",   16'hBC00, 16'h4000, 16'hC000, 3'b000, 16'hC000);
        run_op("truncate",    16'h3C01, 16'h3C01, 16'h3C02, 3'b000, 16'h3C02);
        // specials
        run_op("zero_x_inf",  16'h0000, 16'h7C00, 16'h7E00, 3'b100, 16'h7E00);
        run_op("inf_x_neg",   16'h7C00, 16'hC000, 16'hFC00, 3'b000, 16'hFC00);
        run_op("subn_flush",  16'h0001, 16'h4000, 16'h0000, 3'b000, 16'h0000);
        run_op("nan_in",      16'h7C01, 16'h3C00, 16'h7E00, 3'b100, 16'h7E00);
        // range
        run_op("overflow",    16'h7BFF, 16'h7BFF, 16'h7C00, 3'b010, 16'h7BFF);
        run_op("underflow",   16'h0400, 16'h0400, 16'h0000, 3'b001, 16'h0000);

        // backpressure: result held, inputs ignored
        res_ready = 1'b0;
        issue_and_wait("bp", 16'h3E00, 16'h4000, lat);
        check("bp_latency", lat, 12);
        for (int i = 0; i < 20; i++) begin
            opA = (i % 2 == 0) ? 16'h4400 : 16'h3800;
            req_valid = (i % 3 != 0);
            tick();
            check("bp_valid_hold", res_valid, 1);
            check("bp_res_hold", res, 16'h4200);
            check("bp_flags_hold", flags, 0);
            check("bp_ready_low", req_ready, 0);
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        check("bp_release_valid", res_valid, 0);
        check("bp_release_ready", req_ready, 1);
        tick();
        check("bp_idle_ready", req_ready, 1);
        check("bp_idle_busy", busy, 0);

        // asynchronous reset in the middle of MULT
        check("ar_ready_pre", req_ready, 1);
        opA = 16'h3E00; opB = 16'h4000; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("ar_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_ready", req_ready, 1);
        check("ar_busy", busy, 0);
        check("ar_valid", res_valid, 0);
        check("ar_res", res, 0);
        check("ar_flags", flags, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (res_valid) check("ar_no_result", res_valid, 0);
        end
        check("ar_idle_after", busy, 0);
        run_op("after_reset", 16'h4200, 16'h4000, 16'h4600, 3'b000, 16'h4600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
